// File: rtl/segre_pkg.sv
`default_nettype none
// ============================================================================
// Module      : segre_pkg
// Description : Shared icache refill constants and the refill FSM state type.
//               No ports.
// Revision    : 1.0 - initial release
// ============================================================================
package segre_pkg;

  localparam int WORD_SIZE         = 32;
  localparam int ADDR_SIZE         = 32;
  localparam int ICACHE_LANE_SIZE  = 128;
  localparam int ICACHE_NUM_LANES  = 4;
  localparam int ICACHE_INDEX_SIZE = 2;
  localparam int ICACHE_BYTE_SIZE  = 4;

  localparam int ICACHE_BEATS      = ICACHE_LANE_SIZE / WORD_SIZE;
  localparam int BEAT_CNT_SIZE     = $clog2(ICACHE_BEATS);
  // Shift turning a beat number into a byte offset within the line.
  localparam int WORD_BYTE_SHIFT   = $clog2(WORD_SIZE / 8);

  typedef enum logic [1:0] {
    IC_RF_IDLE  = 2'd0,
    IC_RF_FETCH = 2'd1,
    IC_RF_RESP  = 2'd2
  } ic_refill_state_e;

endpackage
`default_nettype wire

// File: rtl/segre_ic_refill_if.sv
`default_nettype none
// ============================================================================
// Module      : segre_ic_refill_if
// Description : Fetch-stage, memory and MMU-response signals of the icache
//               refill responder.
//               slave  : the refill block (consumes ic_* / mem_valid/data)
//               master : the environment (fetch stage + memory)
// Revision    : 1.0 - initial release
// ============================================================================
interface segre_ic_refill_if;
  import segre_pkg::*;

  logic                         ic_access_i;
  logic                         ic_miss_i;
  logic [ADDR_SIZE-1:0]         ic_addr_i;
  logic                         mem_rd_o;
  logic [ADDR_SIZE-1:0]         mem_addr_o;
  logic                         mem_valid_i;
  logic [WORD_SIZE-1:0]         mem_data_i;
  logic                         mmu_data_o;
  logic [ICACHE_LANE_SIZE-1:0]  mmu_wr_data_o;
  logic [ICACHE_INDEX_SIZE-1:0] mmu_lru_index_o;
  logic                         busy_o;

  modport slave (
    input  ic_access_i, ic_miss_i, ic_addr_i, mem_valid_i, mem_data_i,
    output mem_rd_o, mem_addr_o, mmu_data_o, mmu_wr_data_o, mmu_lru_index_o, busy_o
  );

  modport master (
    output ic_access_i, ic_miss_i, ic_addr_i, mem_valid_i, mem_data_i,
    input  mem_rd_o, mem_addr_o, mmu_data_o, mmu_wr_data_o, mmu_lru_index_o, busy_o
  );

endinterface
`default_nettype wire

// File: rtl/segre_ic_lru.sv
`default_nettype none
// ============================================================================
// Module      : segre_ic_lru
// Description : True-LRU tracker for the fully-associative icache lanes using
//               per-lane age counters (0 = most recent).
// Ports       : clk_i, rsn_i (async, active-high)
//               touch_i  - mark lane index_i most-recently-used
//               index_i  - lane being touched
//               victim_o - least-recently-used lane
// Revision    : 1.0 - initial release
// ============================================================================
module segre_ic_lru
  import segre_pkg::*;
(
  input  wire logic                         clk_i,
  input  wire logic                         rsn_i,
  input  wire logic                         touch_i,
  input  wire logic [ICACHE_INDEX_SIZE-1:0] index_i,
  output logic      [ICACHE_INDEX_SIZE-1:0] victim_o
);

  logic [ICACHE_INDEX_SIZE-1:0] age [ICACHE_NUM_LANES];

  // Lanes younger than the touched one age by one; the touched lane becomes
  // youngest. This keeps the ages a permutation of 0..NUM_LANES-1.
  always_ff @(posedge clk_i or posedge rsn_i) begin
    if (rsn_i) begin
      for (int i = 0; i < ICACHE_NUM_LANES; i++) begin
        age[i] <= ICACHE_INDEX_SIZE'(i);
      end
    end else if (touch_i) begin
      for (int i = 0; i < ICACHE_NUM_LANES; i++) begin
        if (ICACHE_INDEX_SIZE'(i) == index_i) begin
          age[i] <= '0;
        end else if (age[i] < age[index_i]) begin
          age[i] <= age[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    victim_o = '0;
    for (int i = 0; i < ICACHE_NUM_LANES; i++) begin
      if (age[i] == ICACHE_INDEX_SIZE'(ICACHE_NUM_LANES - 1)) begin
        victim_o = ICACHE_INDEX_SIZE'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/segre_ic_refill.sv
`default_nettype none
// ============================================================================
// Module      : segre_ic_refill
// Description : MMU-side icache miss responder. Latches the missing line
//               address, reads the line as word beats from memory and returns
//               it with a victim lane index and a one-cycle write strobe.
//               Maintains true-LRU over the icache lanes.
// Ports       : clk_i, rsn_i (async, active-high)
//               bus (segre_ic_refill_if.slave) - fetch lookup, memory read
//               channel and MMU line-write response
// Revision    : 1.0 - initial release
// ============================================================================
module segre_ic_refill
  import segre_pkg::*;
(
  input  wire logic             clk_i,
  input  wire logic             rsn_i,
  segre_ic_refill_if.slave      bus
);

  localparam logic [BEAT_CNT_SIZE-1:0] LAST_BEAT = BEAT_CNT_SIZE'(ICACHE_BEATS - 1);
  localparam logic [ADDR_SIZE-1:0]     LINE_MASK = ~ADDR_SIZE'((1 << ICACHE_BYTE_SIZE) - 1);

  ic_refill_state_e              state, next_state;
  logic [BEAT_CNT_SIZE-1:0]      beat;
  logic [ADDR_SIZE-1:0]          line_addr;
  logic [ICACHE_LANE_SIZE-1:0]   line_buf;
  logic [ICACHE_LANE_SIZE-1:0]   line_next;
  logic [ICACHE_LANE_SIZE-1:0]   wr_data;
  logic [ICACHE_INDEX_SIZE-1:0]  victim;
  logic [ICACHE_INDEX_SIZE-1:0]  lru_victim;
  logic                          touch;
  logic [ICACHE_INDEX_SIZE-1:0]  touch_index;
  logic                          miss_req;

  assign miss_req = bus.ic_access_i && bus.ic_miss_i;

  segre_ic_lru u_lru (
    .clk_i    (clk_i),
    .rsn_i    (rsn_i),
    .touch_i  (touch),
    .index_i  (touch_index),
    .victim_o (lru_victim)
  );

  always_ff @(posedge clk_i or posedge rsn_i) begin
    if (rsn_i) state <= IC_RF_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    touch       = 1'b0;
    touch_index = '0;
    case (state)
      IC_RF_IDLE: begin
        if (miss_req) begin
          next_state = IC_RF_FETCH;
        end else if (bus.ic_access_i) begin
          touch       = 1'b1;
          touch_index = bus.ic_addr_i[ICACHE_INDEX_SIZE-1:0];
        end
      end
      IC_RF_FETCH: begin
        if (bus.mem_valid_i && (beat == LAST_BEAT)) next_state = IC_RF_RESP;
      end
      IC_RF_RESP: begin
        touch       = 1'b1;
        touch_index = victim;
        next_state  = IC_RF_IDLE;
      end
      default: next_state = IC_RF_IDLE;
    endcase
  end

  // Line with the current beat merged in; on the last beat this is the whole
  // line, so the output register can be loaded directly from it.
  always_comb begin
    line_next = line_buf;
    line_next[WORD_SIZE*beat +: WORD_SIZE] = bus.mem_data_i;
  end

  always_ff @(posedge clk_i or posedge rsn_i) begin
    if (rsn_i) begin
      beat      <= '0;
      line_addr <= '0;
      line_buf  <= '0;
      wr_data   <= '0;
      victim    <= '0;
    end else begin
      case (state)
        IC_RF_IDLE: begin
          if (miss_req) begin
            line_addr <= bus.ic_addr_i & LINE_MASK;
            victim    <= lru_victim;
            beat      <= '0;
          end
        end
        IC_RF_FETCH: begin
          if (bus.mem_valid_i) begin
            line_buf <= line_next;
            beat     <= beat + 1'b1;
            if (beat == LAST_BEAT) wr_data <= line_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_rd_o        = (state == IC_RF_FETCH);
  assign bus.mem_addr_o      = (state == IC_RF_FETCH)
                             ? line_addr + (ADDR_SIZE'(beat) << WORD_BYTE_SHIFT)
                             : '0;
  assign bus.mmu_data_o      = (state == IC_RF_RESP);
  assign bus.mmu_wr_data_o   = wr_data;
  // While idle the fetch stage sees the live victim; once a miss is taken the
  // latched victim is held so index and line stay consistent until written.
  assign bus.mmu_lru_index_o = (state == IC_RF_IDLE) ? lru_victim : victim;
  assign bus.busy_o          = (state != IC_RF_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_segre_ic_refill.sv
`default_nettype none
// ============================================================================
// Module      : tb_segre_ic_refill
// Description : Self-checking bench for segre_ic_refill. A recency-ordered
//               queue models LRU; expected lines are built from the random
//               data words handed to the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_segre_ic_refill;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lru_q[$];          // front = most recently used lane

  segre_ic_refill_if bus ();

  segre_ic_refill dut (
    .clk_i (clk),
    .rsn_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    lru_q = {0, 1, 2, 3};
  endtask

  task automatic model_touch(input int lane);
    for (int i = 0; i < lru_q.size(); i++) begin
      if (lru_q[i] == lane) begin
        lru_q.delete(i);
        break;
      end
    end
    lru_q.push_front(lane);
  endtask

  function automatic int model_victim();
    return lru_q[lru_q.size() - 1];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ic();
    bus.ic_access_i = 1'b0;
    bus.ic_miss_i   = 1'b0;
    bus.ic_addr_i   = '0;
  endtask

  task automatic hit(input int lane);
    bus.ic_access_i = 1'b1;
    bus.ic_miss_i   = 1'b0;
    bus.ic_addr_i   = 32'(lane);
    step();
    clear_ic();
    model_touch(lane);
    chk("hit_victim", 128'(bus.mmu_lru_index_o), 128'(model_victim()));
  endtask

  // Full refill: gap idle cycles (random in [gap_lo,gap_hi]) before each beat;
  // inject drives a competing lookup during the first fetch cycle.
  task automatic refill(input logic [31:0] addr, input int gap_lo, input int gap_hi,
                        input bit inject);
    logic [31:0]  base;
    logic [31:0]  data;
    logic [127:0] line;
    int           v;
    int           gap;
    base = addr & 32'hFFFF_FFF0;
    v    = model_victim();
    line = '0;
    chk("idle_busy", 128'(bus.busy_o), 128'(0));
    chk("idle_victim", 128'(bus.mmu_lru_index_o), 128'(v));
    bus.ic_access_i = 1'b1;
    bus.ic_miss_i   = 1'b1;
    bus.ic_addr_i   = addr;
    step();
    if (inject) begin
      bus.ic_access_i = 1'b1;
      bus.ic_miss_i   = 1'($urandom_range(1, 0));
      bus.ic_addr_i   = 32'h0000_2000 | 32'($urandom_range(3, 0));
    end else begin
      clear_ic();
    end
    for (int b = 0; b < 4; b++) begin
      gap = $urandom_range(gap_hi, gap_lo);
      for (int g = 0; g < gap; g++) begin
        bus.mem_valid_i = 1'b0;
        bus.mem_data_i  = $urandom;
        chk("wait_rd", 128'(bus.mem_rd_o), 128'(1));
        chk("wait_addr", 128'(bus.mem_addr_o), 128'(base + 32'(4 * b)));
        chk("wait_busy", 128'(bus.busy_o), 128'(1));
        step();
        clear_ic();
      end
      data            = $urandom;
      bus.mem_valid_i = 1'b1;
      bus.mem_data_i  = data;
      line[32*b +: 32] = data;
      chk("beat_rd", 128'(bus.mem_rd_o), 128'(1));
      chk("beat_addr", 128'(bus.mem_addr_o), 128'(base + 32'(4 * b)));
      chk("beat_strobe", 128'(bus.mmu_data_o), 128'(0));
      chk("beat_index", 128'(bus.mmu_lru_index_o), 128'(v));
      step();
      clear_ic();
      bus.mem_valid_i = 1'b0;
    end
    chk("resp_strobe", 128'(bus.mmu_data_o), 128'(1));
    chk("resp_line", bus.mmu_wr_data_o, line);
    chk("resp_index", 128'(bus.mmu_lru_index_o), 128'(v));
    chk("resp_rd", 128'(bus.mem_rd_o), 128'(0));
    model_touch(v);
    step();
    chk("post_strobe", 128'(bus.mmu_data_o), 128'(0));
    chk("post_busy", 128'(bus.busy_o), 128'(0));
    chk("post_line_kept", bus.mmu_wr_data_o, line);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_reset();
    step();
  endtask

  initial begin
    clear_ic();
    bus.mem_valid_i = 1'b0;
    bus.mem_data_i  = '0;
    rst = 1'b1;
    model_reset();
    step();
    // Reset state
    chk("rst_rd", 128'(bus.mem_rd_o), 128'(0));
    chk("rst_addr", 128'(bus.mem_addr_o), 128'(0));
    chk("rst_strobe", 128'(bus.mmu_data_o), 128'(0));
    chk("rst_line", bus.mmu_wr_data_o, 128'(0));
    chk("rst_busy", 128'(bus.busy_o), 128'(0));
    chk("rst_index", 128'(bus.mmu_lru_index_o), 128'(3));
    rst = 1'b0;
    step();

    // Back-to-back memory, then one-valid-every-third-cycle
    refill(32'h0000_1234, 0, 0, 1'b0);
    refill(32'h0000_5678, 2, 2, 1'b0);

    // Four misses from reset: victims 3,2,1,0; then hit 3 -> victim 2
    do_reset();
    for (int k = 0; k < 4; k++) begin
      chk("seq_victim", 128'(bus.mmu_lru_index_o), 128'(3 - k));
      refill($urandom, 0, 1, 1'b0);
    end
    hit(3);
    chk("after_hit3", 128'(bus.mmu_lru_index_o), 128'(2));
    refill(32'h0000_0040, 0, 0, 1'b0);

    // Competing lookup during fetch is ignored
    refill(32'h0000_1000, 0, 1, 1'b1);

    // Reset after beat 1 aborts the refill immediately
    bus.ic_access_i = 1'b1;
    bus.ic_miss_i   = 1'b1;
    bus.ic_addr_i   = 32'h0000_3000;
    step();
    clear_ic();
    bus.mem_valid_i = 1'b1;
    bus.mem_data_i  = $urandom;
    step();
    bus.mem_data_i  = $urandom;
    step();
    bus.mem_valid_i = 1'b0;
    chk("pre_abort_rd", 128'(bus.mem_rd_o), 128'(1));
    rst = 1'b1;
    #1;
    chk("abort_rd", 128'(bus.mem_rd_o), 128'(0));
    chk("abort_strobe", 128'(bus.mmu_data_o), 128'(0));
    chk("abort_busy", 128'(bus.busy_o), 128'(0));
    step();
    rst = 1'b0;
    model_reset();
    step();
    chk("abort_line", bus.mmu_wr_data_o, 128'(0));
    refill(32'h0000_3000, 0, 0, 1'b0);

    // mem_valid in IDLE
    bus.mem_valid_i = 1'b1;
    bus.mem_data_i  = $urandom;
    step();
    bus.mem_valid_i = 1'b0;
    chk("idle_valid_busy", 128'(bus.busy_o), 128'(0));
    chk("idle_valid_strobe", 128'(bus.mmu_data_o), 128'(0));
    chk("idle_valid_rd", 128'(bus.mem_rd_o), 128'(0));

    // Random mix of hits and refills
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(1, 0) == 1) hit(int'($urandom_range(3, 0)));
      else refill($urandom, 0, 2, 1'($urandom_range(1, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
